// File: rtl/bram_sdp_pkg.sv
// Shared definitions for the simple-dual-port BRAM with clear sweep.
//   clr_state_e : controller states (idle / clear sweep in progress)
//   be_width()  : number of byte lanes for a given word width
package bram_sdp_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } clr_state_e;

    // One write-enable bit per 8-bit lane.
    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Byte-enabled storage array with one write port and one registered read port.
//   clk_i, rst_i      : clock, asynchronous active-high reset (read pipeline only)
//   we_i/waddr_i/wdata_i/wbe_i : write port, wbe_i bit i gates byte lane i
//   re_i/raddr_i      : read request
//   rdata_o/rvalid_o  : read result, 1 or 2 cycles after re_i (OUTPUT_REG)
// The array itself has no reset; contents are only changed by writes.
module bram_sdp_core
    import bram_sdp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUTPUT_REG = 0,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              we_i,
    input  logic [ADDR_WIDTH-1:0]             waddr_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    input  logic [be_width(DATA_WIDTH)-1:0]   wbe_i,
    input  logic                              re_i,
    input  logic [ADDR_WIDTH-1:0]             raddr_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              rvalid_o
);

    localparam int unsigned BeWidth = be_width(DATA_WIDTH);
    localparam int unsigned Depth   = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic [DATA_WIDTH-1:0] rd_word;

    // Forwarded word merges the enabled write lanes into the stored word so a
    // colliding read sees exactly what the array will hold after this edge.
    always_comb begin
        old_word = mem_q[raddr_i];
        fwd_word = old_word;
        for (int b = 0; b < BeWidth; b++) begin
            if (wbe_i[b]) begin
                fwd_word[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
        rd_word = old_word;
        if ((BYPASS != 0) && we_i && (waddr_i == raddr_i)) begin
            rd_word = fwd_word;
        end
    end

    logic [DATA_WIDTH-1:0] data1_q;
    logic                  valid1_q;

    // Data only loads on an accepted read so the output holds between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data1_q  <= '0;
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= re_i;
            if (re_i) begin
                data1_q <= rd_word;
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] data2_q;
        logic                  valid2_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                data2_q  <= '0;
                valid2_q <= 1'b0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    data2_q <= data1_q;
                end
            end
        end

        assign rdata_o  = data2_q;
        assign rvalid_o = valid2_q;
    end else begin : g_noreg
        assign rdata_o  = data1_q;
        assign rvalid_o = valid1_q;
    end

endmodule

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port BRAM with a full-memory clear sweep.
//   clk, rst          : clock, asynchronous active-high reset (starts a sweep)
//   clr_req           : request a clear sweep (ignored while one is running)
//   clr_busy          : sweep in progress; user reads and writes are ignored
//   wr_en/wr_addr/wr_data/wr_byte_en : byte-enabled write port
//   rd_en/rd_addr     : read request
//   rd_data/rd_valid  : read result, latency 1 (OUTPUT_REG=0) or 2
module bram_sdp_clr
    import bram_sdp_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 11,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           OUTPUT_REG = 0,
    parameter int unsigned           BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr_req,
    output logic                            clr_busy,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [be_width(DATA_WIDTH)-1:0] wr_byte_en,
    input  logic                            rd_en,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_valid
);

    localparam int unsigned BeWidth = be_width(DATA_WIDTH);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                // Leave after the last address is written; cnt never wraps mid-sweep.
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_busy = (state_q == StClear);

    // The sweep owns the write port; user traffic is dropped while it runs.
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [BeWidth-1:0]    core_wbe;
    logic                  core_re;

    always_comb begin
        core_we    = wr_en;
        core_waddr = wr_addr;
        core_wdata = wr_data;
        core_wbe   = wr_byte_en;
        if (clr_busy) begin
            core_we    = 1'b1;
            core_waddr = cnt_q;
            core_wdata = CLR_VALUE;
            core_wbe   = '1;
        end
        core_re = rd_en & ~clr_busy;
    end

    bram_sdp_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OUTPUT_REG (OUTPUT_REG),
        .BYPASS     (BYPASS)
    ) u_core (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (core_we),
        .waddr_i  (core_waddr),
        .wdata_i  (core_wdata),
        .wbe_i    (core_wbe),
        .re_i     (core_re),
        .raddr_i  (rd_addr),
        .rdata_o  (rd_data),
        .rvalid_o (rd_valid)
    );

endmodule
